// File: rtl/t2mi_ts_packetizer_v2.sv
// t2mi_ts_packetizer_v2: buffers pointer-tagged T2-MI bytes and wraps them into fixed-PID TS packets,
// with null-packet fill, optional 204-byte stuffing and an external table-packet insertion slot.
module t2mi_ts_packetizer_v2 #(
    parameter int FIFO_AW   = 8,
    parameter int PKT_LEN   = 188,
    parameter int NULL_FILL = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ENA_IN,
    input  logic [7:0]       DATA_IN,
    input  logic [7:0]       POINTER_IN,
    input  logic [12:0]      t2mi_pid,
    input  logic             TABLE_RDY,
    input  logic [7:0]       TABLE_DATA,
    input  logic             TABLE_ENA,
    input  logic             TABLE_SENT,
    output logic             TABLE_START,
    output logic [7:0]       DATA_OUT,
    output logic             ENA_OUT,
    output logic             PSYNC_OUT,
    output logic             FIFO_OVF,
    output logic [FIFO_AW:0] fifo_level,
    output logic [3:0]       state_mon
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_DECIDE  = 4'd1;
    localparam logic [3:0] S_HDR     = 4'd2;
    localparam logic [3:0] S_PTR     = 4'd3;
    localparam logic [3:0] S_PAYLOAD = 4'd4;
    localparam logic [3:0] S_STUFF   = 4'd5;
    localparam logic [3:0] S_NULLPKT = 4'd6;
    localparam logic [3:0] S_TABLE   = 4'd7;
    localparam logic [3:0] S_END     = (PKT_LEN == 204) ? S_STUFF : S_DECIDE;

    logic [15:0]        mem [2**FIFO_AW];
    logic [15:0]        head;
    logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [3:0]         state_q, state_d, cc_q, cc_d;
    logic [7:0]         cnt_q, cnt_d, p_q, p_d, data_q, data_d, pay_last;
    logic               ovf_q, ovf_d, ena_q, ena_d, psync_q, psync_d;
    logic               tstart_q, tstart_d, first_q, first_d;
    logic               full, wr_en, rd_en;

    assign head     = mem[rd_q];
    assign full     = level_q[FIFO_AW];
    assign rd_en    = state_q == S_PAYLOAD;
    assign wr_en    = ENA_IN && (!full || rd_en);
    assign pay_last = (p_q > 8'd183) ? 8'd183 : 8'd182;

    always_comb begin
        wr_d    = wr_q + FIFO_AW'(wr_en);
        rd_d    = rd_q + FIFO_AW'(rd_en);
        level_d = level_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);
        ovf_d   = ovf_q || (ENA_IN && !wr_en);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        p_d      = p_q;
        cc_d     = cc_q;
        data_d   = 8'h00;
        ena_d    = 1'b1;
        psync_d  = 1'b0;
        tstart_d = 1'b0;
        first_d  = first_q;
        case (state_q)
            S_IDLE: begin
                ena_d   = 1'b0;
                cnt_d   = 8'd0;
                state_d = START ? S_DECIDE : S_IDLE;
            end
            S_DECIDE: begin
                ena_d = 1'b0;
                cnt_d = 8'd0;
                if (TABLE_RDY) begin
                    tstart_d = 1'b1;
                    first_d  = 1'b1;
                    state_d  = S_TABLE;
                end else if (level_q >= (FIFO_AW+1)'(184)) begin
                    p_d     = head[15:8];
                    state_d = S_HDR;
                end else if (NULL_FILL != 0) begin
                    state_d = S_NULLPKT;
                end
            end
            S_HDR: begin
                data_d  = cnt_q == 8'd0 ? 8'h47 :
                          cnt_q == 8'd1 ? {1'b0, p_q < 8'd183, 1'b0, t2mi_pid[12:8]} :
                          cnt_q == 8'd2 ? t2mi_pid[7:0] :
                          {2'b00, p_q == 8'd183 ? 2'b11 : 2'b01, cc_q};
                psync_d = cnt_q == 8'd0;
                if (cnt_q == 8'd3) begin
                    cnt_d   = 8'd0;
                    state_d = p_q > 8'd183 ? S_PAYLOAD : S_PTR;
                end
            end
            S_PTR: begin
                // P==183 means the packet carries a zero-length adaptation field instead of a pointer
                data_d  = p_q == 8'd183 ? 8'h00 : p_q;
                cnt_d   = 8'd0;
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                data_d = head[7:0];
                if (cnt_q == pay_last) begin
                    cnt_d   = 8'd0;
                    cc_d    = cc_q + 4'd1;
                    state_d = S_END;
                end
            end
            S_STUFF: begin
                if (cnt_q == 8'd15) begin
                    cnt_d   = 8'd0;
                    state_d = S_DECIDE;
                end
            end
            S_NULLPKT: begin
                data_d  = cnt_q == 8'd0 ? 8'h47 : cnt_q == 8'd1 ? 8'h1F : cnt_q == 8'd3 ? 8'h10 : 8'hFF;
                psync_d = cnt_q == 8'd0;
                if (cnt_q == 8'd187) begin
                    cnt_d   = 8'd0;
                    state_d = S_END;
                end
            end
            S_TABLE: begin
                data_d  = TABLE_DATA;
                ena_d   = TABLE_ENA;
                psync_d = TABLE_ENA && first_q && TABLE_DATA == 8'h47;
                if (TABLE_ENA) first_d = 1'b0;
                if (TABLE_SENT) begin
                    cnt_d   = 8'd0;
                    state_d = S_END;
                end
            end
            default: begin
                ena_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_q] <= {POINTER_IN, DATA_IN};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            p_q      <= 8'd0;
            cc_q     <= 4'd0;
            data_q   <= 8'd0;
            ena_q    <= 1'b0;
            psync_q  <= 1'b0;
            tstart_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            cc_q     <= cc_d;
            data_q   <= data_d;
            ena_q    <= ena_d;
            psync_q  <= psync_d;
            tstart_q <= tstart_d;
            first_q  <= first_d;
        end
    end

    assign TABLE_START = tstart_q;
    assign DATA_OUT    = data_q;
    assign ENA_OUT     = ena_q;
    assign PSYNC_OUT   = psync_q;
    assign FIFO_OVF    = ovf_q;
    assign fifo_level  = level_q;
    assign state_mon   = state_q;
endmodule
